// File: rtl/regbridge_if.sv
// ARM-side register bus and the shared downstream slave bus of regbridge.
// "master" is the ARM adapter plus slaves view; "slave" is the bridge's own view.
interface regbridge_if #(
    parameter int NSLV = 2
);
    logic [31:0]        armaddr;
    logic [31:0]        armwdata;
    logic [3:0]         armwstrb;
    logic               armwr;
    logic               armreq;
    logic               armack;
    logic               armerr;
    logic [31:0]        armrdata;
    logic [19:0]        slvaddr;
    logic [31:0]        slvwdata;
    logic [3:0]         slvwstrb;
    logic               slvwr;
    logic [NSLV-1:0]    slvreq;
    logic [NSLV-1:0]    slvack;
    logic [NSLV-1:0]    slverr;
    logic [32*NSLV-1:0] slvrdata;

    modport master (
        output armaddr, armwdata, armwstrb, armwr, armreq,
        input  armack, armerr, armrdata,
        input  slvaddr, slvwdata, slvwstrb, slvwr, slvreq,
        output slvack, slverr, slvrdata
    );

    modport slave (
        input  armaddr, armwdata, armwstrb, armwr, armreq,
        output armack, armerr, armrdata,
        output slvaddr, slvwdata, slvwstrb, slvwr, slvreq,
        input  slvack, slverr, slvrdata
    );
endinterface

// File: rtl/regbridge.sv
// ARM register bridge: local control/status/attribute registers plus NSLV forwarded slave regions.
// Optional hung-slave timeout and status counter enabled by defining REGBRIDGE_TIMEOUT_EN.
module regbridge #(
    parameter int NSLV    = 2,
    parameter int ATTRW   = 209,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             reset,
    regbridge_if.slave       bus,
    output logic [ATTRW-1:0] attr,
    output logic             corereset,
    output logic [2:0]       phymode,
    output logic [2:0]       prbssel
);
    localparam int          NW         = (ATTRW + 31) / 32;
    localparam int          PADW       = NW * 32;
    localparam logic [3:0]  LASTREGION = 4'(NSLV);
    localparam logic [19:0] ATTRBASE   = 20'h40;
    localparam logic [19:0] ATTREND    = 20'(64 + 4 * NW);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic             armreq_q, armreqPrev_q;
    logic             armack_q, armack_d;
    logic             armerr_q, armerr_d;
    logic [31:0]      armrdata_q, armrdata_d;
    logic [19:0]      slvaddr_q, slvaddr_d;
    logic [31:0]      slvwdata_q, slvwdata_d;
    logic [3:0]       slvwstrb_q, slvwstrb_d;
    logic             slvwr_q, slvwr_d;
    logic [NSLV-1:0]  slvreq_q, slvreq_d;
    logic [3:0]       slvsel_q, slvsel_d;
    logic             ackSeen_q, ackSeen_d;
    logic             errSeen_q, errSeen_d;
    logic [31:0]      rdSeen_q, rdSeen_d;
    logic [ATTRW-1:0] attr_q, attr_d;
    logic             corereset_q, corereset_d;
    logic [2:0]       phymode_q, phymode_d;
    logic [2:0]       prbssel_q, prbssel_d;
    logic [3:0]       region;
    logic [19:0]      offset;
    logic [19:0]      attrOff;
    logic             reqRise;
    logic [PADW-1:0]  attrPad;
`ifdef REGBRIDGE_TIMEOUT_EN
    logic [15:0]      toCount_q, toCount_d;
    logic [31:0]      timer_q, timer_d;
`endif

    assign region  = bus.armaddr[23:20];
    assign offset  = bus.armaddr[19:0] & ~20'h3;
    assign attrOff = offset - ATTRBASE;
    assign reqRise = armreq_q & ~armreqPrev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            armreq_q     <= 1'b0;
            armreqPrev_q <= 1'b0;
            armack_q     <= 1'b0;
            armerr_q     <= 1'b0;
            armrdata_q   <= '0;
            slvaddr_q    <= '0;
            slvwdata_q   <= '0;
            slvwstrb_q   <= '0;
            slvwr_q      <= 1'b0;
            slvreq_q     <= '0;
            slvsel_q     <= '0;
            ackSeen_q    <= 1'b0;
            errSeen_q    <= 1'b0;
            rdSeen_q     <= '0;
            attr_q       <= '0;
            corereset_q  <= 1'b1;
            phymode_q    <= '0;
            prbssel_q    <= '0;
`ifdef REGBRIDGE_TIMEOUT_EN
            toCount_q    <= '0;
            timer_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            armreq_q     <= bus.armreq;
            armreqPrev_q <= armreq_q;
            armack_q     <= armack_d;
            armerr_q     <= armerr_d;
            armrdata_q   <= armrdata_d;
            slvaddr_q    <= slvaddr_d;
            slvwdata_q   <= slvwdata_d;
            slvwstrb_q   <= slvwstrb_d;
            slvwr_q      <= slvwr_d;
            slvreq_q     <= slvreq_d;
            slvsel_q     <= slvsel_d;
            ackSeen_q    <= ackSeen_d;
            errSeen_q    <= errSeen_d;
            rdSeen_q     <= rdSeen_d;
            attr_q       <= attr_d;
            corereset_q  <= corereset_d;
            phymode_q    <= phymode_d;
            prbssel_q    <= prbssel_d;
`ifdef REGBRIDGE_TIMEOUT_EN
            toCount_q    <= toCount_d;
            timer_q      <= timer_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        armack_d    = 1'b0;
        armerr_d    = armerr_q;
        armrdata_d  = armrdata_q;
        slvaddr_d   = slvaddr_q;
        slvwdata_d  = slvwdata_q;
        slvwstrb_d  = slvwstrb_q;
        slvwr_d     = slvwr_q;
        slvreq_d    = slvreq_q;
        slvsel_d    = slvsel_q;
        corereset_d = corereset_q;
        phymode_d   = phymode_q;
        prbssel_d   = prbssel_q;
        ackSeen_d   = 1'b0;
        errSeen_d   = 1'b0;
        rdSeen_d    = '0;
        attrPad     = '0;
        attrPad[ATTRW-1:0] = attr_q;
`ifdef REGBRIDGE_TIMEOUT_EN
        toCount_d   = toCount_q;
        timer_d     = timer_q;
`endif

        // Slave response is registered once so only the selected, requested port can complete.
        for (int k = 0; k < NSLV; k++) begin
            if (slvsel_q == 4'(k)) begin
                ackSeen_d = bus.slvack[k] & slvreq_q[k] & (state_q == BUSY);
                errSeen_d = bus.slverr[k];
                rdSeen_d  = bus.slvrdata[32*k +: 32];
            end
        end

        case (state_q)
            IDLE: begin
                if (reqRise) begin
                    if (region == 4'd0) begin
                        armack_d = 1'b1;
                        armerr_d = 1'b0;
                        if (offset == 20'h0) begin
                            if (bus.armwr) begin
                                if (bus.armwstrb[3]) corereset_d = ~bus.armwdata[31];
                                if (bus.armwstrb[0]) begin
                                    prbssel_d = bus.armwdata[5:3];
                                    phymode_d = bus.armwdata[2:0];
                                end
                            end else begin
                                armrdata_d = {~corereset_q, 25'd0, prbssel_q, phymode_q};
                            end
                        end else if (offset == 20'h4) begin
`ifdef REGBRIDGE_TIMEOUT_EN
                            if (bus.armwr) toCount_d = '0;
                            else armrdata_d = {16'd0, toCount_q};
`else
                            if (!bus.armwr) armrdata_d = '0;
`endif
                        end else if (offset >= ATTRBASE && offset < ATTREND) begin
                            for (int w = 0; w < NW; w++) begin
                                if (attrOff[19:2] == 18'(w)) begin
                                    if (bus.armwr) begin
                                        for (int b = 0; b < 4; b++)
                                            if (bus.armwstrb[b])
                                                attrPad[32*w+8*b +: 8] = bus.armwdata[8*b +: 8];
                                    end else begin
                                        armrdata_d = attrPad[32*w +: 32];
                                    end
                                end
                            end
                        end else begin
                            armerr_d = 1'b1;
                        end
                    end else if (region <= LASTREGION) begin
                        state_d    = BUSY;
                        slvaddr_d  = bus.armaddr[19:0];
                        slvwdata_d = bus.armwdata;
                        slvwstrb_d = bus.armwr ? bus.armwstrb : 4'h0;
                        slvwr_d    = bus.armwr;
                        slvsel_d   = region - 4'd1;
                        for (int k = 0; k < NSLV; k++)
                            slvreq_d[k] = (region == 4'(k + 1));
`ifdef REGBRIDGE_TIMEOUT_EN
                        timer_d    = '0;
`endif
                    end else begin
                        armack_d = 1'b1;
                        armerr_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (ackSeen_q) begin
                    state_d    = IDLE;
                    slvreq_d   = '0;
                    armack_d   = 1'b1;
                    armerr_d   = errSeen_q;
                    armrdata_d = rdSeen_q;
`ifdef REGBRIDGE_TIMEOUT_EN
                end else if (timer_q == 32'(TIMEOUT - 1)) begin
                    state_d  = IDLE;
                    slvreq_d = '0;
                    armack_d = 1'b1;
                    armerr_d = 1'b1;
                    if (toCount_q != 16'hFFFF) toCount_d = toCount_q + 16'd1;
                end else begin
                    timer_d = timer_q + 32'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        attr_d = attrPad[ATTRW-1:0];
    end

    assign bus.armack   = armack_q;
    assign bus.armerr   = armerr_q;
    assign bus.armrdata = armrdata_q;
    assign bus.slvaddr  = slvaddr_q;
    assign bus.slvwdata = slvwdata_q;
    assign bus.slvwstrb = slvwstrb_q;
    assign bus.slvwr    = slvwr_q;
    assign bus.slvreq   = slvreq_q;
    assign attr         = attr_q;
    assign corereset    = corereset_q;
    assign phymode      = phymode_q;
    assign prbssel      = prbssel_q;
endmodule

// File: tb/tb_regbridge.sv
// Self-checking bench for regbridge: local register vectors from a table, hand-written slave,
// timeout and reset sequences, with completions compared against a queue of expected responses.
module tb_regbridge;
    localparam int NSLV    = 2;
    localparam int ATTRW   = 209;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [ATTRW-1:0] attr;
    logic             corereset;
    logic [2:0]       phymode;
    logic [2:0]       prbssel;

    always #5 clk = ~clk;

    regbridge_if #(.NSLV(NSLV)) bus ();

    regbridge #(
        .NSLV(NSLV),
        .ATTRW(ATTRW),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .attr(attr),
        .corereset(corereset),
        .phymode(phymode),
        .prbssel(prbssel)
    );

    typedef struct {
        logic        err;
        logic [31:0] rd;
        logic        chkRd;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        wr;
        logic        expErr;
        logic [31:0] expRd;
        logic        chkRd;
        logic        expCore;
        logic [2:0]  expPhy;
        logic [2:0]  expPrbs;
    } vec_t;

    exp_t expQ[$];
    vec_t vecs[21];
    int   checks   = 0;
    int   failures = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
        end
    endtask

    // Drives one ARM access and records the response the bridge owes for it.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                                 input logic wr, input logic expErr, input logic [31:0] expRd, input logic chkRd);
        exp_t e;
        @(negedge clk);
        bus.armaddr  = addr;
        bus.armwdata = wdata;
        bus.armwstrb = strb;
        bus.armwr    = wr;
        bus.armreq   = 1'b1;
        e.err   = expErr;
        e.rd    = expRd;
        e.chkRd = chkRd;
        expQ.push_back(e);
    endtask

    // Waits a bounded number of cycles for armack, then compares it with the oldest expectation.
    task automatic waitAck(input int maxCycles, input int expLat, input string name, input bit chkNoSlv);
        int   lat;
        bit   seen;
        exp_t e;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < maxCycles) begin
            @(negedge clk);
            lat++;
            if (bus.armack === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s ack: got none within %0d cycles, expected an ack", name, maxCycles);
            if (expQ.size() > 0) void'(expQ.pop_front());
        end else if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s ack: got unexpected ack, expected none", name);
        end else begin
            e = expQ.pop_front();
            if (expLat >= 0) checkOutput({name, " latency"}, 64'(lat), 64'(expLat));
            checkOutput({name, " err"}, 64'(bus.armerr), 64'(e.err));
            if (e.chkRd) checkOutput({name, " rdata"}, 64'(bus.armrdata), 64'(e.rd));
            if (chkNoSlv) checkOutput({name, " slvreq idle"}, 64'(bus.slvreq), 64'(0));
        end
        bus.armreq = 1'b0;
        @(negedge clk);
        if (seen) checkOutput({name, " ack single"}, 64'(bus.armack), 64'(0));
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acks;

        vecs[0]  = '{32'h00000000, 32'h0,        4'hF, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 3'd0, 3'd0};
        vecs[1]  = '{32'h00000000, 32'h8000002B, 4'hF, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 3'd3, 3'd5};
        vecs[2]  = '{32'h00000000, 32'h0,        4'hF, 1'b0, 1'b0, 32'h8000002B, 1'b1, 1'b0, 3'd3, 3'd5};
        vecs[3]  = '{32'h00000044, 32'hAABBCCDD, 4'h5, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 3'd3, 3'd5};
        vecs[4]  = '{32'h00000044, 32'h0,        4'hF, 1'b0, 1'b0, 32'h00BB00DD, 1'b1, 1'b0, 3'd3, 3'd5};
        vecs[5]  = '{32'h00000058, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 3'd3, 3'd5};
        vecs[6]  = '{32'h00000058, 32'h0,        4'hF, 1'b0, 1'b0, 32'h0001FFFF, 1'b1, 1'b0, 3'd3, 3'd5};
        vecs[7]  = '{32'h00000100, 32'h0,        4'hF, 1'b0, 1'b1, 32'h0001FFFF, 1'b1, 1'b0, 3'd3, 3'd5};
        vecs[8]  = '{32'h00300000, 32'h0,        4'hF, 1'b0, 1'b1, 32'h0001FFFF, 1'b1, 1'b0, 3'd3, 3'd5};
        vecs[9]  = '{32'h0000005C, 32'h0,        4'hF, 1'b0, 1'b1, 32'h0001FFFF, 1'b1, 1'b0, 3'd3, 3'd5};
        vecs[10] = '{32'h00000008, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b1, 32'h0001FFFF, 1'b1, 1'b0, 3'd3, 3'd5};
        vecs[11] = '{32'h00000000, 32'h00000012, 4'h8, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 3'd3, 3'd5};
        vecs[12] = '{32'h00000003, 32'h800000FF, 4'h1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 3'd7, 3'd7};
        vecs[13] = '{32'h00000000, 32'h0,        4'hF, 1'b0, 1'b0, 32'h0000003F, 1'b1, 1'b1, 3'd7, 3'd7};
        vecs[14] = '{32'h00000000, 32'h8000002B, 4'h9, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 3'd3, 3'd5};
        vecs[15] = '{32'h00000048, 32'h0,        4'hF, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 3'd3, 3'd5};
        vecs[16] = '{32'h00000043, 32'h11223344, 4'hF, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 3'd3, 3'd5};
        vecs[17] = '{32'h00000040, 32'h0,        4'hF, 1'b0, 1'b0, 32'h11223344, 1'b1, 1'b0, 3'd3, 3'd5};
        vecs[18] = '{32'h00000004, 32'h0,        4'hF, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 3'd3, 3'd5};
        vecs[19] = '{32'h00000004, 32'h0,        4'hF, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 3'd3, 3'd5};
        vecs[20] = '{32'h00000000, 32'h0,        4'hF, 1'b0, 1'b0, 32'h8000002B, 1'b1, 1'b0, 3'd3, 3'd5};

        reset        = 1'b1;
        bus.armaddr  = '0;
        bus.armwdata = '0;
        bus.armwstrb = '0;
        bus.armwr    = 1'b0;
        bus.armreq   = 1'b0;
        bus.slvack   = '0;
        bus.slverr   = '0;
        bus.slvrdata = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset corereset", 64'(corereset), 64'(1));
        checkOutput("reset armack", 64'(bus.armack), 64'(0));
        checkOutput("reset slvreq", 64'(bus.slvreq), 64'(0));
        checkOutput("reset attr", 64'(attr == '0), 64'(1));
        checkOutput("reset phy/prbs", 64'({prbssel, phymode}), 64'(0));
        checkOutput("reset armrdata", 64'(bus.armrdata), 64'(0));
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 21; i++) begin
            applyStimulus(vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].wr,
                          vecs[i].expErr, vecs[i].expRd, vecs[i].chkRd);
            waitAck(10, 2, $sformatf("vec%0d", i), 1'b1);
            checkOutput($sformatf("vec%0d corereset", i), 64'(corereset), 64'(vecs[i].expCore));
            checkOutput($sformatf("vec%0d phymode", i), 64'(phymode), 64'(vecs[i].expPhy));
            checkOutput($sformatf("vec%0d prbssel", i), 64'(prbssel), 64'(vecs[i].expPrbs));
        end
        checkOutput("attr word0", 64'(attr[31:0]), 64'h11223344);
        checkOutput("attr word1", 64'(attr[63:32]), 64'h00BB00DD);
        checkOutput("attr word5", 64'(attr[191:160]), 64'h0);
        checkOutput("attr top", 64'(attr[208:192]), 64'h1FFFF);

        // Slave 1 read with a late ack and a spurious ack from the unselected slave 0.
        applyStimulus(32'h00200010, 32'h0, 4'hF, 1'b0, 1'b0, 32'h12345678, 1'b1);
        @(negedge clk);
        checkOutput("slv1Read slvreq early", 64'(bus.slvreq), 64'(0));
        @(negedge clk);
        checkOutput("slv1Read slvreq", 64'(bus.slvreq), 64'b10);
        checkOutput("slv1Read slvaddr", 64'(bus.slvaddr), 64'h00010);
        checkOutput("slv1Read slvwr", 64'(bus.slvwr), 64'(0));
        checkOutput("slv1Read slvwstrb", 64'(bus.slvwstrb), 64'(0));
        bus.slvack[0] = 1'b1;
        bus.slverr[0] = 1'b1;
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.armack) acks++;
        end
        checkOutput("slv1Read spurious ack", 64'(acks), 64'(0));
        checkOutput("slv1Read slvreq held", 64'(bus.slvreq), 64'b10);
        bus.slvack[0] = 1'b0;
        @(negedge clk);
        bus.slvrdata[63:32] = 32'h12345678;
        bus.slverr[1]       = 1'b0;
        bus.slvack[1]       = 1'b1;
        waitAck(6, 2, "slv1Read", 1'b1);
        bus.slvack[1] = 1'b0;
        bus.slverr[0] = 1'b0;

        // Slave 0 write acked with error in the first cycle slvreq is high.
        bus.slvrdata[31:0] = 32'hCAFEF00D;
        applyStimulus(32'h00100123, 32'hDEADBEEF, 4'h3, 1'b1, 1'b1, 32'hCAFEF00D, 1'b1);
        repeat (2) @(negedge clk);
        checkOutput("slv0Write slvreq", 64'(bus.slvreq), 64'b01);
        checkOutput("slv0Write slvaddr", 64'(bus.slvaddr), 64'h00123);
        checkOutput("slv0Write slvwdata", 64'(bus.slvwdata), 64'hDEADBEEF);
        checkOutput("slv0Write slvwstrb", 64'(bus.slvwstrb), 64'h3);
        checkOutput("slv0Write slvwr", 64'(bus.slvwr), 64'(1));
        bus.slvack[0] = 1'b1;
        bus.slverr[0] = 1'b1;
        waitAck(6, 2, "slv0Write", 1'b1);
        bus.slvack[0] = 1'b0;
        bus.slverr[0] = 1'b0;

`ifdef REGBRIDGE_TIMEOUT_EN
        applyStimulus(32'h00100000, 32'h0, 4'hF, 1'b0, 1'b1, 32'hCAFEF00D, 1'b1);
        waitAck(40, TIMEOUT + 2, "timeout", 1'b1);
        applyStimulus(32'h00000004, 32'h0, 4'hF, 1'b0, 1'b0, 32'h00000001, 1'b1);
        waitAck(10, 2, "status after timeout", 1'b1);
        applyStimulus(32'h00000004, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        waitAck(10, 2, "status clear", 1'b1);
        applyStimulus(32'h00000004, 32'h0, 4'hF, 1'b0, 1'b0, 32'h00000000, 1'b1);
        waitAck(10, 2, "status cleared", 1'b1);
`else
        applyStimulus(32'h00100000, 32'h0, 4'hF, 1'b0, 1'b0, 32'h55AA55AA, 1'b1);
        acks = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.armack) acks++;
        end
        checkOutput("noTimeout no ack", 64'(acks), 64'(0));
        checkOutput("noTimeout slvreq", 64'(bus.slvreq), 64'b01);
        bus.slvrdata[31:0] = 32'h55AA55AA;
        bus.slvack[0]      = 1'b1;
        waitAck(6, 2, "noTimeout", 1'b1);
        bus.slvack[0] = 1'b0;
        applyStimulus(32'h00000004, 32'h0, 4'hF, 1'b0, 1'b0, 32'h00000000, 1'b1);
        waitAck(10, 2, "status disabled", 1'b1);
`endif

        // Asynchronous reset while slave 1 is busy: no completion may follow.
        @(negedge clk);
        bus.armaddr = 32'h00200000;
        bus.armwr   = 1'b0;
        bus.armreq  = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rstAbort slvreq busy", 64'(bus.slvreq), 64'b10);
        #2 reset = 1'b1;
        #1;
        checkOutput("rstAbort slvreq", 64'(bus.slvreq), 64'(0));
        checkOutput("rstAbort corereset", 64'(corereset), 64'(1));
        checkOutput("rstAbort attr", 64'(attr == '0), 64'(1));
        checkOutput("rstAbort phymode", 64'(phymode), 64'(0));
        bus.armreq = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        acks  = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.armack) acks++;
        end
        checkOutput("rstAbort no ack", 64'(acks), 64'(0));
        applyStimulus(32'h00000000, 32'h0, 4'hF, 1'b0, 1'b0, 32'h00000000, 1'b1);
        waitAck(10, 2, "postRst ctrl", 1'b1);
        applyStimulus(32'h00200008, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0BADF00D, 1'b1);
        repeat (2) @(negedge clk);
        bus.slvrdata[63:32] = 32'h0BADF00D;
        bus.slvack[1]       = 1'b1;
        waitAck(6, 2, "postRst slv1", 1'b1);
        bus.slvack[1] = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regbridge.md
# regbridge

Parametrised successor to the ARM-side register block. Decodes ARM register-bus accesses by `armaddr[23:20]`. Region 0 is served by a local readable register file: control, status and a generic-width attribute bank. Regions 1..NSLV are forwarded to NSLV downstream slave ports (AUX, DEBUG, future peripherals) over one shared request bus, with byte-strobe support and a hung-slave timeout. Sits between the AXI-lite-to-req/ack adapter and the DisplayPort core.

## Interface
- `NSLV`, 2: number of downstream slave ports, 1..15; port k serves region k+1.
- `ATTRW`, 209: attribute vector width, 1..512.
- `TIMEOUT`, 1023: slave timeout in cycles, ≥ 2.
- `clk` in 1: sole clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `armaddr` in 32: byte address; [23:20] region, [19:0] offset.
- `armwdata` in 32: write data.
- `armwstrb` in 4: byte-lane write enables.
- `armwr` in 1: 1 = write, 0 = read.
- `armreq` in 1: request level; a rising edge starts an access.
- `armack` out 1: one-cycle completion pulse.
- `armerr` out 1: error flag, valid with `armack`.
- `armrdata` out 32: read data, valid with `armack`.
- `slvaddr` out 20: offset forwarded to slave.
- `slvwdata` out 32, `slvwstrb` out 4, `slvwr` out 1: forwarded write data, strobes and direction.
- `slvreq` out NSLV: one-hot request level.
- `slvack` in NSLV: per-slave acknowledge.
- `slverr` in NSLV: per-slave error, valid with ack.
- `slvrdata` in 32*NSLV: per-slave read data; slave k uses bits [32k+31:32k].
- `attr` out ATTRW: attribute vector to the core.
- `corereset` out 1: core reset, active-high.
- `phymode` out 3, `prbssel` out 3: PHY mode and PRBS select.

## Operation
- Reset values:
  - `corereset`=1.
  - `armack`, `armerr`, `armrdata`, `attr`, `phymode`, `prbssel`, `slvreq`, `slvaddr`, `slvwdata`, `slvwstrb`, `slvwr`, timeout counter = 0.
  - FSM = IDLE.
- FSM states IDLE and BUSY. A rising edge of `armreq` (registered delayed copy) is acted on only in IDLE; rising edges seen in BUSY are dropped.
- Region 0 (IDLE, stays IDLE), offsets taken as `armaddr[19:0] & ~3`:
  - 0x00 control: bit31 = !`corereset`, [5:3] `prbssel`, [2:0] `phymode`.
    - Writes honour strobes: bit31 needs `armwstrb[3]`; [5:0] need `armwstrb[0]`.
    - Reads return the current values, other bits 0.
  - 0x04 status: [15:0] saturating slave-timeout count, upper bits 0. Any write clears it.
  - 0x40+4i, i = 0..ceil(ATTRW/32)-1: `attr[32i+31:32i]`.
    - Each byte is written only where its strobe is set.
    - Bits ≥ ATTRW are ignored on write and read as 0.
  - Any other offset: `armack`=1, `armerr`=1, no state change, `armrdata` unchanged.
- Regions 1..NSLV: go to BUSY.
  - Latch `slvaddr`=`armaddr[19:0]`, `slvwdata`, `slvwstrb` (forced to 0 for reads) and `slvwr`.
  - Set `slvreq[region-1]`.
- Regions > NSLV: error completion, as for an unmapped local offset.
- In BUSY, only the selected slave's `slvack` is honoured; it clears `slvreq`, pulses `armack`, copies that slave's `slverr` to `armerr`, loads `armrdata` from its `slvrdata` slice, and returns to IDLE.

## Timing
- Rising edge of `armreq` registered at edge N. For local or error accesses, `armack` is high for the cycle after edge N+1 and register updates are visible at the same edge.
- Slave access: `slvreq` is high after edge N+1.
  - `slvack` sampled high at edge M: `slvreq` drops and `armack` pulses after edge M+1.
  - Slaves may ack in the first cycle `slvreq` is high.
- `armack` is never high for two consecutive cycles.
- Timeout (see Configuration): counts BUSY cycles. On the TIMEOUT-th cycle without ack:
  - `slvreq` drops, `armack`=1, `armerr`=1, `armrdata` unchanged.
  - The counter increments, saturating at 0xFFFF.
  - If ack and expiry occur in the same cycle, the ack wins.
- Reset asserted mid-access: outputs go to reset values immediately; no `armack` is issued.

## Configuration
- `REGBRIDGE_TIMEOUT_EN` defined: timeout logic and status counter present as above.
- Undefined: BUSY waits indefinitely for ack; status register reads 0; writes to 0x04 ack without error; the `TIMEOUT` parameter is unused.

## Test plan
- Write 0x8000002B to 0x000000, strobes 0xF:
  - `corereset`=0, `prbssel`=5, `phymode`=3, ack 2 cycles after the edge, `armerr`=0.
  - Read back returns 0x8000002B.
- Write 0xAABBCCDD to 0x000044 with strobe 0x5: `attr[63:32]` = 0x00BB00DD. With ATTRW=209, write 0xFFFFFFFF to 0x000058: only `attr[208:192]` set; read returns 0x0001FFFF.
- Read 0x200010, NSLV=2:
  - `slvreq`=2'b10 and `slvaddr`=0x00010.
  - Slave 1 acks after 5 cycles with rdata 0x12345678, err 0 → `armrdata`=0x12345678.
  - Spurious `slvack[0]` during BUSY is ignored.
- Read offset 0x000100, and read region 3 with NSLV=2: both give an immediate ack with `armerr`=1; no `slvreq` asserted.
- With `REGBRIDGE_TIMEOUT_EN` and TIMEOUT=16, silent slave 0:
  - Error ack after 16 BUSY cycles; status reads 1.
  - Write 0x04 → reads 0.
- Assert `reset` while slave 1 is BUSY: `slvreq`=0 and `corereset`=1 asynchronously; no ack; next access is serviced normally.
